// File: rtl/alu_control_seq_if.sv
// -----------------------------------------------------------------------------
// alu_control_seq_if
//
// Purpose:
//   Bundles the instruction-side and result-side signals of the ALU control
//   sequencer so the decoder and its upstream pipeline stage share one port.
//   Clock and reset are not part of the bundle; they stay plain module ports.
//
// Signals:
//   i_enable     pipeline advance, output register loads only when high
//   i_flush      kill the current and the captured instruction
//   i_valid      opcode/funct carry a real instruction
//   i_opcode     instruction opcode              (NB_OPCODE bits)
//   i_funct      instruction funct field         (NB_FUNCTION bits)
//   o_alu_op     registered ALU operation code   (NB_OP_ALU bits)
//   o_shift_var  registered, shift amount taken from rs instead of shamt
//   o_valid      registered, o_alu_op holds a live instruction
//   o_illegal    registered, captured instruction not in the decode table
//   o_md_start   one-cycle pulse launching the multiply/divide unit
//   o_md_op      registered multiply/divide op: 00 MULT 01 MULTU 10 DIV 11 DIVU
//   o_md_done    one-cycle pulse, multiply/divide result ready
//   o_stall      high while multiply/divide is busy; upstream must hold
//
// Modports:
//   master  upstream pipeline stage (drives i_*, observes o_*)
//   slave   the sequencer itself    (observes i_*, drives o_*)
// -----------------------------------------------------------------------------
interface alu_control_seq_if #(
    parameter int NB_FUNCTION = 6,
    parameter int NB_OPCODE   = 6,
    parameter int NB_OP_ALU   = 6
);

    logic                   i_enable;
    logic                   i_flush;
    logic                   i_valid;
    logic [NB_OPCODE-1:0]   i_opcode;
    logic [NB_FUNCTION-1:0] i_funct;

    logic [NB_OP_ALU-1:0]   o_alu_op;
    logic                   o_shift_var;
    logic                   o_valid;
    logic                   o_illegal;
    logic                   o_md_start;
    logic [1:0]             o_md_op;
    logic                   o_md_done;
    logic                   o_stall;

    // Upstream stage: presents instructions, reacts to stall and results.
    modport master (
        output i_enable,
        output i_flush,
        output i_valid,
        output i_opcode,
        output i_funct,
        input  o_alu_op,
        input  o_shift_var,
        input  o_valid,
        input  o_illegal,
        input  o_md_start,
        input  o_md_op,
        input  o_md_done,
        input  o_stall
    );

    // Sequencer: consumes instructions, produces decoded controls.
    modport slave (
        input  i_enable,
        input  i_flush,
        input  i_valid,
        input  i_opcode,
        input  i_funct,
        output o_alu_op,
        output o_shift_var,
        output o_valid,
        output o_illegal,
        output o_md_start,
        output o_md_op,
        output o_md_done,
        output o_stall
    );

endinterface

// File: rtl/alu_control_seq.sv
// -----------------------------------------------------------------------------
// alu_control_seq
//
// Purpose:
//   Decodes a MIPS-style opcode/funct pair into an ALU operation code, a
//   variable-shift flag and an illegal-instruction flag, all held in a single
//   output register that advances with the pipeline enable. Multiply/divide
//   instructions additionally launch a fixed-latency multiply/divide sequence:
//   a one-cycle start pulse, MD_LATENCY cycles of stall, then a one-cycle done
//   pulse. A flush kills the captured instruction and any sequence in flight.
//
// Ports:
//   clock   single clock, all state updates on its rising edge
//   reset   synchronous, active-high; overrides flush, enable and busy
//   bus     alu_control_seq_if.slave (instruction in, decoded controls out)
//
// Parameters:
//   NB_FUNCTION  width of funct field            (default 6)
//   NB_OPCODE    width of opcode field           (default 6)
//   NB_OP_ALU    width of ALU operation code     (default 6)
//   MD_LATENCY   busy cycles per mult/div op     (default 32, legal 2..255)
//   The widths must match the ones the interface instance was built with.
// -----------------------------------------------------------------------------
module alu_control_seq #(
    parameter int NB_FUNCTION = 6,
    parameter int NB_OPCODE   = 6,
    parameter int NB_OP_ALU   = 6,
    parameter int MD_LATENCY  = 32
) (
    input  logic               clock,
    input  logic               reset,
    alu_control_seq_if.slave   bus
);

    // Sequencer states. DONE behaves like IDLE for accepting new input but
    // additionally flags the one cycle in which the result is ready.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Eight bits cover the whole legal latency range.
    localparam int NB_CNT = 8;

    // ALU operation codes produced by the decoder.
    localparam logic [NB_OP_ALU-1:0] ALU_SLL = NB_OP_ALU'(6'b000000);
    localparam logic [NB_OP_ALU-1:0] ALU_SRL = NB_OP_ALU'(6'b000010);
    localparam logic [NB_OP_ALU-1:0] ALU_SRA = NB_OP_ALU'(6'b000011);
    localparam logic [NB_OP_ALU-1:0] ALU_LUI = NB_OP_ALU'(6'b001111);
    localparam logic [NB_OP_ALU-1:0] ALU_ADD = NB_OP_ALU'(6'b100000);
    localparam logic [NB_OP_ALU-1:0] ALU_SUB = NB_OP_ALU'(6'b100010);
    localparam logic [NB_OP_ALU-1:0] ALU_AND = NB_OP_ALU'(6'b100100);
    localparam logic [NB_OP_ALU-1:0] ALU_OR  = NB_OP_ALU'(6'b100101);
    localparam logic [NB_OP_ALU-1:0] ALU_XOR = NB_OP_ALU'(6'b100110);
    localparam logic [NB_OP_ALU-1:0] ALU_NOR = NB_OP_ALU'(6'b100111);
    localparam logic [NB_OP_ALU-1:0] ALU_SLT = NB_OP_ALU'(6'b101010);

    localparam logic [NB_OPCODE-1:0] OPC_RTYPE = NB_OPCODE'(6'b000000);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [NB_CNT-1:0]    counter_q;
    logic [NB_CNT-1:0]    counter_d;

    logic [NB_OP_ALU-1:0] aluOp_q;
    logic                 shiftVar_q;
    logic                 valid_q;
    logic                 illegal_q;
    logic                 mdStart_q;
    logic [1:0]           mdOp_q;

    logic [NB_OP_ALU-1:0] decAluOp;
    logic                 decShiftVar;
    logic                 decIllegal;
    logic                 decMd;

    logic                 stallNow;
    logic                 loadEn;
    logic                 mdLaunch;

    // Pure combinational decode of the presented instruction. Anything not
    // recognised falls through to ADD with the illegal flag set, which keeps
    // the datapath doing something harmless while the flag reports it.
    // Multiply/divide ops also drive ADD on the ALU; the real work happens in
    // the separate multiply/divide unit.
    always_comb begin
        decAluOp    = ALU_ADD;
        decShiftVar = 1'b0;
        decIllegal  = 1'b0;
        decMd       = 1'b0;
        if (bus.i_opcode == OPC_RTYPE) begin
            case (bus.i_funct)
                NB_FUNCTION'(6'b000000): decAluOp = ALU_SLL;
                NB_FUNCTION'(6'b000010): decAluOp = ALU_SRL;
                NB_FUNCTION'(6'b000011): decAluOp = ALU_SRA;
                NB_FUNCTION'(6'b000100): begin
                    decAluOp    = ALU_SLL;
                    decShiftVar = 1'b1;
                end
                NB_FUNCTION'(6'b000110): begin
                    decAluOp    = ALU_SRL;
                    decShiftVar = 1'b1;
                end
                NB_FUNCTION'(6'b000111): begin
                    decAluOp    = ALU_SRA;
                    decShiftVar = 1'b1;
                end
                NB_FUNCTION'(6'b001000): decAluOp = ALU_ADD;
                NB_FUNCTION'(6'b001001): decAluOp = ALU_ADD;
                NB_FUNCTION'(6'b011000): decMd    = 1'b1;
                NB_FUNCTION'(6'b011001): decMd    = 1'b1;
                NB_FUNCTION'(6'b011010): decMd    = 1'b1;
                NB_FUNCTION'(6'b011011): decMd    = 1'b1;
                NB_FUNCTION'(6'b100001): decAluOp = ALU_ADD;
                NB_FUNCTION'(6'b100011): decAluOp = ALU_SUB;
                NB_FUNCTION'(6'b100100): decAluOp = ALU_AND;
                NB_FUNCTION'(6'b100101): decAluOp = ALU_OR;
                NB_FUNCTION'(6'b100110): decAluOp = ALU_XOR;
                NB_FUNCTION'(6'b100111): decAluOp = ALU_NOR;
                NB_FUNCTION'(6'b101010): decAluOp = ALU_SLT;
                default:                 decIllegal = 1'b1;
            endcase
        end else begin
            case (bus.i_opcode)
                NB_OPCODE'(6'b001000): decAluOp = ALU_ADD;
                NB_OPCODE'(6'b001001): decAluOp = ALU_ADD;
                NB_OPCODE'(6'b001100): decAluOp = ALU_AND;
                NB_OPCODE'(6'b001101): decAluOp = ALU_OR;
                NB_OPCODE'(6'b001110): decAluOp = ALU_XOR;
                NB_OPCODE'(6'b001010): decAluOp = ALU_SLT;
                NB_OPCODE'(6'b001111): decAluOp = ALU_LUI;
                NB_OPCODE'(6'b100000): decAluOp = ALU_ADD;
                NB_OPCODE'(6'b100001): decAluOp = ALU_ADD;
                NB_OPCODE'(6'b100011): decAluOp = ALU_ADD;
                NB_OPCODE'(6'b100100): decAluOp = ALU_ADD;
                NB_OPCODE'(6'b100101): decAluOp = ALU_ADD;
                NB_OPCODE'(6'b100111): decAluOp = ALU_ADD;
                NB_OPCODE'(6'b101000): decAluOp = ALU_ADD;
                NB_OPCODE'(6'b101001): decAluOp = ALU_ADD;
                NB_OPCODE'(6'b101011): decAluOp = ALU_ADD;
                NB_OPCODE'(6'b000100): decAluOp = ALU_SUB;
                NB_OPCODE'(6'b000101): decAluOp = ALU_SUB;
                NB_OPCODE'(6'b000010): decAluOp = ALU_ADD;
                NB_OPCODE'(6'b000011): decAluOp = ALU_ADD;
                default:               decIllegal = 1'b1;
            endcase
        end
    end

    // The output register only loads when the pipeline advances, nothing is
    // stalling it and no flush is killing the instruction. A multiply/divide
    // sequence is launched only by a real (valid) instruction being loaded.
    assign stallNow = (state_q == ST_BUSY);
    assign loadEn   = bus.i_enable && !stallNow && !bus.i_flush;
    assign mdLaunch = loadEn && bus.i_valid && decMd;

    // Next-state logic for the multiply/divide sequencer. The counter is
    // loaded with MD_LATENCY-1 and BUSY exits when it reaches zero, which
    // gives exactly MD_LATENCY busy cycles. Flush abandons the sequence from
    // any state, so no done pulse is ever seen for a killed operation.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        if (bus.i_flush) begin
            state_d   = ST_IDLE;
            counter_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (mdLaunch) begin
                        state_d   = ST_BUSY;
                        counter_d = NB_CNT'(MD_LATENCY - 1);
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (counter_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        counter_d = counter_q - NB_CNT'(1);
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    counter_d = '0;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    // Output register. A flush clears the validity-related flags but leaves
    // the op code fields alone since nothing downstream trusts them without
    // o_valid. The start pulse is simply the registered launch condition, so
    // it can only ever last one cycle. The illegal flag only reports real
    // instructions; a bubble is never illegal.
    always_ff @(posedge clock) begin
        if (reset) begin
            aluOp_q    <= '0;
            shiftVar_q <= 1'b0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            mdStart_q  <= 1'b0;
            mdOp_q     <= 2'b00;
        end else if (bus.i_flush) begin
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
            mdStart_q  <= 1'b0;
        end else begin
            mdStart_q <= mdLaunch;
            if (loadEn) begin
                aluOp_q    <= decAluOp;
                shiftVar_q <= decShiftVar;
                valid_q    <= bus.i_valid;
                illegal_q  <= bus.i_valid && decIllegal;
            end
            if (mdLaunch) begin
                mdOp_q <= bus.i_funct[1:0];
            end
        end
    end

    assign bus.o_alu_op    = aluOp_q;
    assign bus.o_shift_var = shiftVar_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_illegal   = illegal_q;
    assign bus.o_md_start  = mdStart_q;
    assign bus.o_md_op     = mdOp_q;
    assign bus.o_md_done   = (state_q == ST_DONE);
    assign bus.o_stall     = stallNow;

endmodule

// File: tb/tb_alu_control_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_control_seq
//
// Purpose:
//   Self-checking bench for alu_control_seq with MD_LATENCY=4. A table-driven
//   decode reference plus a cycle-count model of the multiply/divide timing
//   produce every expected value; directed scenarios and a randomized run
//   compare the DUT outputs against them.
// -----------------------------------------------------------------------------
module tb_alu_control_seq;

    localparam int NBF = 6;
    localparam int NBO = 6;
    localparam int NBA = 6;
    localparam int LAT = 4;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    // Decode reference tables, -1 marks "not in the table".
    int aluOfFunct [64];
    int aluOfOpcode[64];

    // Reference model of the registered outputs.
    logic [5:0] mAlu;
    bit         mShift;
    bit         mValid;
    bit         mIllegal;
    bit         mStart;
    bit         mDone;
    logic [1:0] mMdOp;
    int         mStallLeft = 0;

    alu_control_seq_if #(.NB_FUNCTION(NBF), .NB_OPCODE(NBO), .NB_OP_ALU(NBA)) bus ();

    alu_control_seq #(
        .NB_FUNCTION(NBF),
        .NB_OPCODE  (NBO),
        .NB_OP_ALU  (NBA),
        .MD_LATENCY (LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Global guard so the run always ends even if the design locks up.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Fill the decode tables straight from the instruction list.
    task automatic initTables();
        for (int i = 0; i < 64; i++) begin
            aluOfFunct[i]  = -1;
            aluOfOpcode[i] = -1;
        end
        aluOfFunct[0]  = 0;  aluOfFunct[2]  = 2;  aluOfFunct[3]  = 3;
        aluOfFunct[4]  = 0;  aluOfFunct[6]  = 2;  aluOfFunct[7]  = 3;
        aluOfFunct[33] = 32; aluOfFunct[35] = 34; aluOfFunct[36] = 36;
        aluOfFunct[37] = 37; aluOfFunct[38] = 38; aluOfFunct[39] = 39;
        aluOfFunct[42] = 42; aluOfFunct[8]  = 32; aluOfFunct[9]  = 32;
        aluOfOpcode[8]  = 32; aluOfOpcode[9]  = 32; aluOfOpcode[12] = 36;
        aluOfOpcode[13] = 37; aluOfOpcode[14] = 38; aluOfOpcode[10] = 42;
        aluOfOpcode[15] = 15; aluOfOpcode[32] = 32; aluOfOpcode[33] = 32;
        aluOfOpcode[35] = 32; aluOfOpcode[36] = 32; aluOfOpcode[37] = 32;
        aluOfOpcode[39] = 32; aluOfOpcode[40] = 32; aluOfOpcode[41] = 32;
        aluOfOpcode[43] = 32; aluOfOpcode[4]  = 34; aluOfOpcode[5]  = 34;
        aluOfOpcode[2]  = 32; aluOfOpcode[3]  = 32;
    endtask

    // Reference decode of one instruction.
    function automatic void refDecode(input logic [5:0] op, input logic [5:0] fn,
                                      output logic [5:0] alu, output bit sv,
                                      output bit ill, output bit md);
        int code;
        md   = (op == 6'd0) && (fn >= 6'd24) && (fn <= 6'd27);
        sv   = (op == 6'd0) && (fn == 6'd4 || fn == 6'd6 || fn == 6'd7);
        code = md ? 32 : ((op == 6'd0) ? aluOfFunct[fn] : aluOfOpcode[op]);
        ill  = (code < 0);
        alu  = ill ? 6'd32 : 6'(code);
    endfunction

    // Advance the model by one clock edge using the inputs present at it.
    // mStallLeft counts the remaining stalled cycles of a mult/div op.
    task automatic modelStep();
        logic [5:0] a;
        bit sv, il, md;
        if (reset) begin
            mAlu = '0; mShift = 0; mValid = 0; mIllegal = 0;
            mStart = 0; mDone = 0; mMdOp = '0; mStallLeft = 0;
        end else if (bus.i_flush) begin
            mValid = 0; mIllegal = 0; mStart = 0; mDone = 0; mStallLeft = 0;
        end else if (mStallLeft > 0) begin
            mDone  = (mStallLeft == 1);
            mStart = 0;
            mStallLeft--;
        end else begin
            mDone  = 0;
            mStart = 0;
            if (bus.i_enable) begin
                refDecode(bus.i_opcode, bus.i_funct, a, sv, il, md);
                mAlu     = a;
                mShift   = sv;
                mValid   = bus.i_valid;
                mIllegal = bus.i_valid && il;
                if (bus.i_valid && md) begin
                    mStart     = 1;
                    mMdOp      = bus.i_funct[1:0];
                    mStallLeft = LAT;
                end
            end
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        modelStep();
        #1;
    endtask

    task automatic applyStimulus(input bit en, input bit fl, input bit v,
                                 input logic [5:0] op, input logic [5:0] fn);
        bus.i_enable = en;
        bus.i_flush  = fl;
        bus.i_valid  = v;
        bus.i_opcode = op;
        bus.i_funct  = fn;
    endtask

    // Return the sequencer to a quiet idle state.
    task automatic settle();
        applyStimulus(1'b0, 1'b1, 1'b0, 6'd0, 6'd0);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 6'd0, 6'd24);
        tick();
        tick();
        checks++; if (bus.o_alu_op !== 6'd0) begin failures++; $display("[TB] FAIL reset_alu_op got=%0h want=0", bus.o_alu_op); end
        checks++; if (bus.o_shift_var !== 1'b0) begin failures++; $display("[TB] FAIL reset_shift_var got=%0b want=0", bus.o_shift_var); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b want=0", bus.o_valid); end
        checks++; if (bus.o_illegal !== 1'b0) begin failures++; $display("[TB] FAIL reset_illegal got=%0b want=0", bus.o_illegal); end
        checks++; if (bus.o_md_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_md_start got=%0b want=0", bus.o_md_start); end
        checks++; if (bus.o_md_op !== 2'b00) begin failures++; $display("[TB] FAIL reset_md_op got=%0b want=00", bus.o_md_op); end
        checks++; if (bus.o_md_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_md_done got=%0b want=0", bus.o_md_done); end
        checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%0b want=0", bus.o_stall); end
        reset = 1'b0;
    endtask

    task automatic test_decode_sweep();
        logic [5:0] a;
        logic [5:0] fn;
        bit sv, il, md;
        settle();
        for (int i = 0; i < 128; i++) begin
            fn = (i < 64) ? 6'(i) : 6'($urandom_range(0, 63));
            if (i < 64 && (i >= 24 && i <= 27)) continue;
            if (i == 64) continue;
            applyStimulus(1'b1, 1'b0, 1'b1, (i < 64) ? 6'd0 : 6'(i - 64), fn);
            refDecode(bus.i_opcode, bus.i_funct, a, sv, il, md);
            tick();
            checks++; if (bus.o_alu_op !== a) begin failures++; $display("[TB] FAIL sweep_alu_op op=%0d fn=%0d got=%0h want=%0h", bus.i_opcode, bus.i_funct, bus.o_alu_op, a); end
            checks++; if (bus.o_shift_var !== sv) begin failures++; $display("[TB] FAIL sweep_shift_var op=%0d fn=%0d got=%0b want=%0b", bus.i_opcode, bus.i_funct, bus.o_shift_var, sv); end
            checks++; if (bus.o_illegal !== il || bus.o_valid !== 1'b1) begin failures++; $display("[TB] FAIL sweep_flags op=%0d fn=%0d got=ill%0b/v%0b want=ill%0b/v1", bus.i_opcode, bus.i_funct, bus.o_illegal, bus.o_valid, il); end
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 6'b101111);
        tick();
        checks++; if (bus.o_illegal !== 1'b1 || bus.o_alu_op !== 6'b100000) begin failures++; $display("[TB] FAIL sweep_illegal_101111 got=ill%0b/alu%0h want=ill1/alu20", bus.o_illegal, bus.o_alu_op); end
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 6'b101111);
        tick();
        checks++; if (bus.o_illegal !== 1'b0 || bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL sweep_bubble_not_illegal got=ill%0b/v%0b want=ill0/v0", bus.o_illegal, bus.o_valid); end
    endtask

    task automatic test_mult_timing();
        settle();
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 6'b011000);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
        checks++; if (bus.o_md_op !== 2'b00 || bus.o_alu_op !== 6'b100000) begin failures++; $display("[TB] FAIL mult_op got=md%0b/alu%0h want=md00/alu20", bus.o_md_op, bus.o_alu_op); end
        for (int k = 1; k <= LAT + 2; k++) begin
            checks++; if (bus.o_md_start !== (k == 1)) begin failures++; $display("[TB] FAIL mult_start cycle=%0d got=%0b want=%0b", k, bus.o_md_start, (k == 1)); end
            checks++; if (bus.o_stall !== (k <= LAT)) begin failures++; $display("[TB] FAIL mult_stall cycle=%0d got=%0b want=%0b", k, bus.o_stall, (k <= LAT)); end
            checks++; if (bus.o_md_done !== (k == LAT + 1)) begin failures++; $display("[TB] FAIL mult_done cycle=%0d got=%0b want=%0b", k, bus.o_md_done, (k == LAT + 1)); end
            tick();
        end
    endtask

    task automatic test_busy_hold();
        int n;
        settle();
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 6'b011001);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 6'b100100);
        tick();
        checks++; if (bus.o_alu_op !== 6'b100000 || bus.o_md_op !== 2'b01 || bus.o_valid !== 1'b1) begin failures++; $display("[TB] FAIL busy_hold got=alu%0h/md%0b/v%0b want=alu20/md01/v1", bus.o_alu_op, bus.o_md_op, bus.o_valid); end
        n = 0;
        while (!bus.o_md_done && n < LAT + 3) begin
            n++;
            tick();
        end
        checks++; if (bus.o_md_done !== 1'b1 || bus.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL busy_reach_done got=done%0b/stall%0b want=done1/stall0", bus.o_md_done, bus.o_stall); end
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 6'b100001);
        tick();
        checks++; if (bus.o_alu_op !== 6'b100000 || bus.o_valid !== 1'b1 || bus.o_md_start !== 1'b0) begin failures++; $display("[TB] FAIL done_load_addu got=alu%0h/v%0b/st%0b want=alu20/v1/st0", bus.o_alu_op, bus.o_valid, bus.o_md_start); end
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 6'b100110);
        tick();
        checks++; if (bus.o_alu_op !== 6'b100110 || bus.o_md_done !== 1'b0) begin failures++; $display("[TB] FAIL idle_load_xor got=alu%0h/done%0b want=alu26/done0", bus.o_alu_op, bus.o_md_done); end
    endtask

    task automatic test_flush();
        int seen;
        settle();
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 6'b011011);
        tick();
        checks++; if (bus.o_md_op !== 2'b11 || bus.o_md_start !== 1'b1) begin failures++; $display("[TB] FAIL divu_launch got=md%0b/st%0b want=md11/st1", bus.o_md_op, bus.o_md_start); end
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 6'd0, 6'b011000);
        tick();
        checks++; if (bus.o_stall !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_illegal !== 1'b0) begin failures++; $display("[TB] FAIL flush_clear got=stall%0b/v%0b/ill%0b want=0/0/0", bus.o_stall, bus.o_valid, bus.o_illegal); end
        checks++; if (bus.o_md_start !== 1'b0 || bus.o_md_done !== 1'b0) begin failures++; $display("[TB] FAIL flush_pulses got=st%0b/done%0b want=0/0", bus.o_md_start, bus.o_md_done); end
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
        seen = 0;
        for (int k = 0; k < LAT + 2; k++) begin
            tick();
            if (bus.o_md_done || bus.o_stall) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL flush_no_done got=%0d want=0", seen); end
    endtask

    task automatic test_back_to_back();
        int n;
        settle();
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 6'b011010);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
        n = 0;
        while (!bus.o_md_done && n < LAT + 3) begin
            n++;
            tick();
        end
        checks++; if (bus.o_md_done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_done got=%0b want=1", bus.o_md_done); end
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 6'b011010);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
        checks++; if (bus.o_md_start !== 1'b1 || bus.o_stall !== 1'b1 || bus.o_md_op !== 2'b10 || bus.o_md_done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_restart got=st%0b/stall%0b/md%0b/done%0b want=1/1/10/0", bus.o_md_start, bus.o_stall, bus.o_md_op, bus.o_md_done); end
        n = 0;
        while (bus.o_stall && n < LAT + 3) begin
            n++;
            tick();
        end
        checks++; if (n !== LAT || bus.o_md_done !== 1'b1) begin failures++; $display("[TB] FAIL b2b_stall_len got=%0d/done%0b want=%0d/done1", n, bus.o_md_done, LAT); end
    endtask

    task automatic test_reset_mid_busy();
        settle();
        applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 6'b011001);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 6'd0, 6'b011000);
        tick();
        reset = 1'b0;
        checks++; if (bus.o_alu_op !== 6'd0 || bus.o_md_op !== 2'b00 || bus.o_shift_var !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy_fields got=alu%0h/md%0b/sv%0b want=0/00/0", bus.o_alu_op, bus.o_md_op, bus.o_shift_var); end
        checks++; if (bus.o_stall !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_md_start !== 1'b0 || bus.o_md_done !== 1'b0 || bus.o_illegal !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy_flags got=stall%0b/v%0b/st%0b/done%0b/ill%0b want=all0", bus.o_stall, bus.o_valid, bus.o_md_start, bus.o_md_done, bus.o_illegal); end
        applyStimulus(1'b0, 1'b0, 1'b1, 6'b001100, 6'd0);
        tick();
        tick();
        checks++; if (bus.o_alu_op !== 6'd0 || bus.o_valid !== 1'b0 || bus.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL enable_low_hold got=alu%0h/v%0b/stall%0b want=0/0/0", bus.o_alu_op, bus.o_valid, bus.o_stall); end
    endtask

    task automatic test_random();
        logic [5:0] op;
        logic [5:0] fn;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                op = 6'd0;
                fn = ($urandom_range(0, 3) == 0) ? 6'(24 + $urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            end else begin
                op = 6'($urandom_range(0, 63));
                fn = 6'($urandom_range(0, 63));
            end
            reset = ($urandom_range(0, 59) == 0);
            applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 24) == 0,
                          $urandom_range(0, 9) < 7, op, fn);
            tick();
            checks++; if (bus.o_alu_op !== mAlu) begin failures++; $display("[TB] FAIL rand_alu_op i=%0d got=%0h want=%0h", i, bus.o_alu_op, mAlu); end
            checks++; if (bus.o_shift_var !== mShift) begin failures++; $display("[TB] FAIL rand_shift_var i=%0d got=%0b want=%0b", i, bus.o_shift_var, mShift); end
            checks++; if (bus.o_valid !== mValid) begin failures++; $display("[TB] FAIL rand_valid i=%0d got=%0b want=%0b", i, bus.o_valid, mValid); end
            checks++; if (bus.o_illegal !== mIllegal) begin failures++; $display("[TB] FAIL rand_illegal i=%0d got=%0b want=%0b", i, bus.o_illegal, mIllegal); end
            checks++; if (bus.o_md_start !== mStart) begin failures++; $display("[TB] FAIL rand_md_start i=%0d got=%0b want=%0b", i, bus.o_md_start, mStart); end
            checks++; if (bus.o_md_op !== mMdOp) begin failures++; $display("[TB] FAIL rand_md_op i=%0d got=%0b want=%0b", i, bus.o_md_op, mMdOp); end
            checks++; if (bus.o_md_done !== mDone) begin failures++; $display("[TB] FAIL rand_md_done i=%0d got=%0b want=%0b", i, bus.o_md_done, mDone); end
            checks++; if (bus.o_stall !== (mStallLeft > 0)) begin failures++; $display("[TB] FAIL rand_stall i=%0d got=%0b want=%0b", i, bus.o_stall, (mStallLeft > 0)); end
        end
        reset = 1'b0;
    endtask

    // Scenario sequence, then the single summary line.
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
        initTables();
        test_reset();
        test_decode_sweep();
        test_mult_timing();
        test_busy_hold();
        test_flush();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
